// File: rtl/vga_overlay_gen.sv
// VGA timing generator with frame-buffer request, image window and box/crosshair overlays.
// Three stages: counters/request (0), flags + coordinates (1), pixel mux + registered outputs (2).
module vga_overlay_gen #(
    parameter int unsigned H_SYNC    = 136,
    parameter int unsigned H_BACK    = 160,
    parameter int unsigned H_ADDR    = 1024,
    parameter int unsigned H_FRONT   = 24,
    parameter int unsigned V_SYNC    = 6,
    parameter int unsigned V_BACK    = 29,
    parameter int unsigned V_ADDR    = 768,
    parameter int unsigned V_FRONT   = 3,
    parameter int unsigned IMG_W     = 640,
    parameter int unsigned IMG_H     = 480,
    parameter int unsigned IMG_X0    = 0,
    parameter int unsigned IMG_Y0    = 0,
    parameter int unsigned BOX_N     = 2,
    parameter bit          SYNC_POL  = 1'b1,
    parameter logic [15:0] OVL_COLOR = 16'hF800
) (
    input  logic                 sclk,
    input  logic                 s_rst_n,
    input  logic [BOX_N-1:0]     box_en,
    input  logic [11*BOX_N-1:0]  box_x_min,
    input  logic [11*BOX_N-1:0]  box_x_max,
    input  logic [10*BOX_N-1:0]  box_y_min,
    input  logic [10*BOX_N-1:0]  box_y_max,
    input  logic                 cross_en,
    input  logic [10:0]          cross_x,
    input  logic [9:0]           cross_y,
    output logic                 data_req,
    input  logic [15:0]          img_data,
    output logic                 vga_hsync,
    output logic                 vga_vsync,
    output logic                 vga_de,
    output logic [15:0]          vga_rgb,
    output logic [10:0]          vga_x,
    output logic [9:0]           vga_y,
    output logic                 frame_start
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ADDR + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ADDR + V_FRONT;
    localparam int unsigned H_START = H_SYNC + H_BACK;
    localparam int unsigned V_START = V_SYNC + V_BACK;
    localparam int unsigned HCW     = $clog2(H_TOTAL + 1);
    localparam int unsigned VCW     = $clog2(V_TOTAL + 1);
    localparam int unsigned XW      = 11;
    localparam int unsigned YW      = 10;
    localparam logic        SYNC_IDLE = ~SYNC_POL;

    // stage 0: raster counters
    logic [HCW-1:0] r_cnt_h;
    logic [VCW-1:0] r_cnt_v;
    logic           w_h_last;
    logic           w_v_last;
    logic           w_origin;
    logic [HCW-1:0] w_hoff;
    logic [VCW-1:0] w_voff;
    logic           w_active;
    logic [XW-1:0]  w_ax;
    logic [YW-1:0]  w_ay;
    logic [XW:0]    w_img_dx;
    logic [YW:0]    w_img_dy;
    logic           w_in_img;

    assign w_h_last = (r_cnt_h == HCW'(H_TOTAL - 1));
    assign w_v_last = (r_cnt_v == VCW'(V_TOTAL - 1));
    assign w_origin = (r_cnt_h == '0) && (r_cnt_v == '0);

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_cnt_h <= '0;
            r_cnt_v <= '0;
        end else if (w_h_last) begin
            r_cnt_h <= '0;
            r_cnt_v <= w_v_last ? '0 : r_cnt_v + VCW'(1);
        end else begin
            r_cnt_h <= r_cnt_h + HCW'(1);
        end
    end

    // offsets wrap above the counter range before the active start, so one compare covers both edges
    assign w_hoff   = r_cnt_h - HCW'(H_START);
    assign w_voff   = r_cnt_v - VCW'(V_START);
    assign w_active = (w_hoff < HCW'(H_ADDR)) && (w_voff < VCW'(V_ADDR));
    assign w_ax     = XW'(w_hoff);
    assign w_ay     = YW'(w_voff);
    assign w_img_dx = (XW+1)'({1'b0, w_ax} - (XW+1)'(IMG_X0));
    assign w_img_dy = (YW+1)'({1'b0, w_ay} - (YW+1)'(IMG_Y0));
    assign w_in_img = w_active && (w_img_dx < (XW+1)'(IMG_W)) && (w_img_dy < (YW+1)'(IMG_H));

    assign data_req    = w_in_img;
    assign frame_start = s_rst_n && w_origin;

    // overlay shadows, reloaded once per frame at the counter origin
    logic [BOX_N-1:0]    r_sh_box_en;
    logic [XW*BOX_N-1:0] r_sh_x_min;
    logic [XW*BOX_N-1:0] r_sh_x_max;
    logic [YW*BOX_N-1:0] r_sh_y_min;
    logic [YW*BOX_N-1:0] r_sh_y_max;
    logic                r_sh_cross_en;
    logic [XW-1:0]       r_sh_cross_x;
    logic [YW-1:0]       r_sh_cross_y;

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_sh_box_en   <= '0;
            r_sh_x_min    <= '0;
            r_sh_x_max    <= '0;
            r_sh_y_min    <= '0;
            r_sh_y_max    <= '0;
            r_sh_cross_en <= 1'b0;
            r_sh_cross_x  <= '0;
            r_sh_cross_y  <= '0;
        end else if (w_origin) begin
            r_sh_box_en   <= box_en;
            r_sh_x_min    <= box_x_min;
            r_sh_x_max    <= box_x_max;
            r_sh_y_min    <= box_y_min;
            r_sh_y_max    <= box_y_max;
            r_sh_cross_en <= cross_en;
            r_sh_cross_x  <= cross_x;
            r_sh_cross_y  <= cross_y;
        end
    end

    // stage 1: flags and active-area coordinates
    logic          r_s1_active;
    logic          r_s1_img;
    logic          r_s1_hs;
    logic          r_s1_vs;
    logic [XW-1:0] r_s1_ax;
    logic [YW-1:0] r_s1_ay;

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_s1_active <= 1'b0;
            r_s1_img    <= 1'b0;
            r_s1_hs     <= 1'b0;
            r_s1_vs     <= 1'b0;
            r_s1_ax     <= '0;
            r_s1_ay     <= '0;
        end else begin
            r_s1_active <= w_active;
            r_s1_img    <= w_in_img;
            r_s1_hs     <= (r_cnt_h < HCW'(H_SYNC));
            r_s1_vs     <= (r_cnt_v < VCW'(V_SYNC));
            r_s1_ax     <= w_active ? w_ax : '0;
            r_s1_ay     <= w_active ? w_ay : '0;
        end
    end

    // box edge detection; a box with min > max on either axis is suppressed
    logic [BOX_N-1:0] w_box_edge;

    for (genvar gi = 0; gi < BOX_N; gi++) begin : g_box
        logic [XW-1:0] w_xl, w_xh;
        logic [YW-1:0] w_yl, w_yh;
        logic          w_valid, w_in_x, w_in_y, w_on_y, w_on_x;

        assign w_xl    = r_sh_x_min[XW*gi +: XW];
        assign w_xh    = r_sh_x_max[XW*gi +: XW];
        assign w_yl    = r_sh_y_min[YW*gi +: YW];
        assign w_yh    = r_sh_y_max[YW*gi +: YW];
        assign w_valid = r_sh_box_en[gi] && (w_xl <= w_xh) && (w_yl <= w_yh);
        assign w_in_x  = (r_s1_ax >= w_xl) && (r_s1_ax <= w_xh);
        assign w_in_y  = (r_s1_ay >= w_yl) && (r_s1_ay <= w_yh);
        assign w_on_y  = (r_s1_ay == w_yl) || (r_s1_ay == w_yh);
        assign w_on_x  = (r_s1_ax == w_xl) || (r_s1_ax == w_xh);
        assign w_box_edge[gi] = w_valid && ((w_on_y && w_in_x) || (w_on_x && w_in_y));
    end

    logic        w_cross;
    logic [15:0] w_rgb;

    assign w_cross = r_sh_cross_en && ((r_s1_ax == r_sh_cross_x) || (r_s1_ay == r_sh_cross_y));

    always_comb begin
        w_rgb = 16'h0000;
        if (r_s1_active) begin
            if ((|w_box_edge) || w_cross) begin
                w_rgb = OVL_COLOR;
            end else if (r_s1_img) begin
                w_rgb = img_data;
            end
        end
    end

    // stage 2: registered video outputs
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            vga_hsync <= SYNC_IDLE;
            vga_vsync <= SYNC_IDLE;
            vga_de    <= 1'b0;
            vga_rgb   <= '0;
            vga_x     <= '0;
            vga_y     <= '0;
        end else begin
            vga_hsync <= r_s1_hs ? SYNC_POL : SYNC_IDLE;
            vga_vsync <= r_s1_vs ? SYNC_POL : SYNC_IDLE;
            vga_de    <= r_s1_active;
            vga_rgb   <= w_rgb;
            vga_x     <= r_s1_ax;
            vga_y     <= r_s1_ay;
        end
    end

endmodule

// File: doc/vga_overlay_gen.md
VGA_OVERLAY_GEN -- requirements
Module: vga_overlay_gen

Interface
REQ-001 SHALL provide parameters (name, default, meaning), one per line:
  H_SYNC 136, hsync width (pixels)
  H_BACK 160, h back porch
  H_ADDR 1024, h active pixels
  H_FRONT 24, h front porch
  V_SYNC 6, vsync width (lines)
  V_BACK 29, v back porch
  V_ADDR 768, v active lines
  V_FRONT 3, v front porch
  IMG_W 640, image window width
  IMG_H 480, image window height
  IMG_X0 0, image window x offset in active area
  IMG_Y0 0, image window y offset in active area
  BOX_N 2, number of rectangle overlays
  SYNC_POL 1, sync active level (1 = active-high)
  OVL_COLOR 16'hF800, overlay colour (RGB565 red)
REQ-002 SHALL provide ports (name, direction, width, meaning), one per line:
  sclk  in  1  pixel clock
  s_rst_n  in  1  reset, asynchronous, active-low
  box_en  in  BOX_N  per-box enable
  box_x_min, box_x_max  in  11*BOX_N  box i at bits [11i+10:11i]
  box_y_min, box_y_max  in  10*BOX_N  box i at bits [10i+9:10i]
  cross_en  in  1  crosshair enable
  cross_x  in  11  crosshair column
  cross_y  in  10  crosshair row
  data_req  out  1  pixel request to frame buffer
  img_data  in  16  RGB565 pixel, valid the cycle after data_req
  vga_hsync, vga_vsync  out  1  syncs
  vga_de  out  1  active-area display enable
  vga_rgb  out  16  RGB565 pixel
  vga_x  out  11  active-area column of vga_rgb
  vga_y  out  10  active-area row of vga_rgb
  frame_start  out  1  one-cycle pulse at counter origin
REQ-003 SHALL use sclk as the only clock; reset is s_rst_n, asynchronous, active-low.

Function
REQ-004 SHALL run cnt_h 0..H_TOTAL-1 (H_TOTAL = sum of H params), wrapping to 0; cnt_v increments when cnt_h wraps and wraps to 0 after V_TOTAL-1. No off-by-one extra count.
REQ-005 Stage 0 (counters) SHALL define active = cnt_h in [H_SYNC+H_BACK, +H_ADDR) and cnt_v in [V_SYNC+V_BACK, +V_ADDR); ax/ay = offset of the counters inside the active area.
REQ-006 data_req SHALL be combinational from stage 0 and high iff active and ax in [IMG_X0, IMG_X0+IMG_W) and ay in [IMG_Y0, IMG_Y0+IMG_H); exactly IMG_W*IMG_H requests per frame.
REQ-007 Stage 1 SHALL register flags, ax and ay; img_data is sampled in stage 1.
REQ-008 Stage 2 SHALL register all video outputs, so vga_hsync, vga_vsync, vga_de, vga_rgb, vga_x and vga_y are exactly 2 cycles behind the counters and mutually aligned.
REQ-009 Sync outputs SHALL equal SYNC_POL while cnt_h < H_SYNC (resp. cnt_v < V_SYNC), else ~SYNC_POL.
REQ-010 vga_x/vga_y SHALL be ax/ay when active, else 0.
REQ-011 Pixel priority (active only), highest first:
  - box edge -> OVL_COLOR
  - crosshair -> OVL_COLOR
  - image window -> img_data
  - else 16'h0000
  Outside active, vga_rgb SHALL be 0.
REQ-012 Box i edge SHALL be drawn iff shadow box_en[i], x_min<=x_max, y_min<=y_max, and either:
  - ay equals y_min or y_max with ax in [x_min, x_max], or
  - ax equals x_min or x_max with ay in [y_min, y_max].
  A box with min>max SHALL not be drawn.
REQ-013 Crosshair SHALL be drawn iff shadow cross_en and (ax==cross_x or ay==cross_y); it is drawn over the whole active area, including outside the image window.
REQ-014 All overlay inputs SHALL be captured into shadow registers on the cycle cnt_h==0 and cnt_v==0; frame_start SHALL pulse on that cycle. Mid-frame input changes SHALL take effect next frame only.
REQ-015 All comparisons SHALL be unsigned at declared widths; active-area coordinates SHALL never exceed 11/10 bits.

Reset
REQ-016 While s_rst_n is low:
  - counters, pipeline and shadow registers (box_en, cross_en, coordinates) SHALL be 0
  - vga_rgb, vga_x, vga_y, vga_de, frame_start SHALL be 0
  - syncs SHALL be ~SYNC_POL
  - data_req SHALL be 0
REQ-017 Assertion mid-line SHALL take effect immediately (asynchronous). After release, the first clock edge sees counters at 0, and frame_start pulses during that cycle.

Verification
REQ-018 Defaults, reset release -> hsync high 136 of every 1344 cycles; vsync high 6*1344 of every 1344*806 cycles; vga_de high for 1024x768 per frame.
REQ-019 Count data_req over one frame -> 307200; first request at cnt_v=35, cnt_h=296; vga_rgb equals the returned img_data 2 cycles later at vga_x=0, vga_y=0.
REQ-020 Box 0 enabled at (100,50)-(200,150) before frame_start:
  - (100,60) -> 16'hF800
  - (150,100) -> img_data
  - (201,50) -> img_data
REQ-021 Box 0 moved mid-frame -> current frame unchanged; new position drawn from next frame.
REQ-022 Box with x_min=300, x_max=200 -> not drawn. cross_x=1000, cross_y=700 -> 16'hF800 at column 1000 on background outside the image window.
REQ-023 s_rst_n pulsed low mid-line -> outputs at reset values within the same cycle; timing restarts from counter 0.
